// File: rtl/synaptic_weight_accumulator.sv
// Frame-based accumulator of excitatory and inhibitory synaptic weights (signed Q-format),
// with saturating sums, a saturating beat counter and a hold/handshake stage for the consumer.
module synaptic_weight_accumulator #(
  parameter int INTEGER_WIDTH   = 32,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         SpikeValid,
  output logic                         SpikeReady,
  input  logic signed [DATA_WIDTH-1:0] SpikeWeight,
  input  logic                         SpikeInhibitory,
  input  logic                         SpikeLast,
  output logic signed [DATA_WIDTH-1:0] ExWeightSum,
  output logic signed [DATA_WIDTH-1:0] InWeightSum,
  output logic                         SumValid,
  input  logic                         SumAccept,
  output logic [COUNT_WIDTH-1:0]       SpikeCount,
  output logic                         Overflow,
  output logic                         Busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [DATA_WIDTH-1:0] SUM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SUM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                 state_reg;
  logic [DATA_WIDTH-1:0]  sum_reg   [2];
  logic [DATA_WIDTH-1:0]  lane_next [2];
  logic [1:0]             lane_sat;
  logic [1:0]             lane_hit;
  logic                   beat_accept;

  // SpikeReady is itself the registered "state == ACCUM" flag.
  assign beat_accept = SpikeValid && SpikeReady;

  // Lane 0 carries the excitatory sum, lane 1 the inhibitory sum.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [DATA_WIDTH:0] wide_sum;
      assign wide_sum = {sum_reg[gi][DATA_WIDTH-1], sum_reg[gi]}
                      + {SpikeWeight[DATA_WIDTH-1], SpikeWeight};
      // Sign bit and its extension disagree only when the true sum left the signed range.
      assign lane_sat[gi]  = wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1];
      assign lane_next[gi] = lane_sat[gi] ? (wide_sum[DATA_WIDTH] ? SUM_MIN : SUM_MAX)
                                          : wide_sum[DATA_WIDTH-1:0];
      assign lane_hit[gi]  = beat_accept && ((gi == 1) ? SpikeInhibitory : !SpikeInhibitory);
    end
  endgenerate

  assign ExWeightSum = sum_reg[0];
  assign InWeightSum = sum_reg[1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      sum_reg[0] <= '0;
      sum_reg[1] <= '0;
      SpikeCount <= '0;
      Overflow   <= 1'b0;
      SumValid   <= 1'b0;
      SpikeReady <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            state_reg  <= ACCUM;
            sum_reg[0] <= '0;
            sum_reg[1] <= '0;
            SpikeCount <= '0;
            Overflow   <= 1'b0;
            SpikeReady <= 1'b1;
            Busy       <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat_accept) begin
            for (int i = 0; i < 2; i++) begin
              if (lane_hit[i]) sum_reg[i] <= lane_next[i];
            end
            if (|(lane_hit & lane_sat)) Overflow <= 1'b1;
            if (SpikeCount != {COUNT_WIDTH{1'b1}}) SpikeCount <= SpikeCount + COUNT_WIDTH'(1);
            if (SpikeLast) begin
              state_reg  <= HOLD;
              SpikeReady <= 1'b0;
              SumValid   <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Start arriving together with SumAccept is deliberately dropped.
          if (SumAccept) begin
            state_reg <= IDLE;
            SumValid  <= 1'b0;
            Busy      <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          SumValid   <= 1'b0;
          SpikeReady <= 1'b0;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
// Directed self-checking bench for synaptic_weight_accumulator (Q32.32 defaults).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_synaptic_weight_accumulator;

  localparam int DW = 64;
  localparam int CW = 16;

  localparam logic [DW-1:0] P1_0   = 64'h00000001_00000000;
  localparam logic [DW-1:0] P0_5   = 64'h00000000_80000000;
  localparam logic [DW-1:0] P2_25  = 64'h00000002_40000000;
  localparam logic [DW-1:0] P3_25  = 64'h00000003_40000000;
  localparam logic [DW-1:0] P2_0   = 64'h00000002_00000000;
  localparam logic [DW-1:0] BIG    = 64'h7FFFFFFF_00000000;
  localparam logic [DW-1:0] SATMAX = 64'h7FFFFFFF_FFFFFFFF;
  localparam logic [DW-1:0] SATMIN = 64'h80000000_00000000;
  localparam logic [DW-1:0] M1_0   = 64'hFFFFFFFF_00000000;
  localparam logic [DW-1:0] M3_0   = 64'hFFFFFFFD_00000000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start, spike_valid, spike_inh, spike_last, sum_accept;
  logic signed [DW-1:0] spike_weight;
  logic                 spike_ready, sum_valid, overflow, busy;
  logic signed [DW-1:0] ex_sum, in_sum;
  logic [CW-1:0]        spike_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  synaptic_weight_accumulator dut (
    .Clock(clk), .Reset(rst), .Start(start),
    .SpikeValid(spike_valid), .SpikeReady(spike_ready), .SpikeWeight(spike_weight),
    .SpikeInhibitory(spike_inh), .SpikeLast(spike_last),
    .ExWeightSum(ex_sum), .InWeightSum(in_sum),
    .SumValid(sum_valid), .SumAccept(sum_accept),
    .SpikeCount(spike_count), .Overflow(overflow), .Busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] w, input logic inh, input logic last);
    spike_valid = 1'b1; spike_weight = w; spike_inh = inh; spike_last = last;
    tick();
    spike_valid = 1'b0; spike_last = 1'b0; spike_inh = 1'b0; spike_weight = '0;
  endtask

  task automatic accept();
    sum_accept = 1'b1;
    tick();
    sum_accept = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; spike_valid = 0; spike_inh = 0; spike_last = 0;
    sum_accept = 0; spike_weight = '0;
    tick();
    checks++;
    if ({ex_sum, in_sum} !== {DW*2{1'b0}} || spike_count !== '0 ||
        {sum_valid, spike_ready, overflow, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: ex=%h in=%h cnt=%0d flags=%b required all zero",
               ex_sum, in_sum, spike_count, {sum_valid, spike_ready, overflow, busy});
    end
    rst = 1'b0;
    tick();
    $display("reset: released");
  endtask

  task automatic test_basic();
    do_start();
    checks++;
    if ({spike_ready, busy, sum_valid} !== 3'b110 || spike_count !== '0) begin
      errors++;
      $display("FAIL start_accum: ready/busy/valid=%b cnt=%0d required 110 cnt=0",
               {spike_ready, busy, sum_valid}, spike_count);
    end
    beat(P1_0, 1'b0, 1'b0);
    checks++;
    if (ex_sum !== P1_0 || spike_count !== 16'd1) begin
      errors++;
      $display("FAIL beat1_latency: ex=%h cnt=%0d required %h cnt=1", ex_sum, spike_count, P1_0);
    end
    beat(P0_5, 1'b1, 1'b0);
    checks++;
    if (sum_valid !== 1'b0 || in_sum !== P0_5 || ex_sum !== P1_0) begin
      errors++;
      $display("FAIL beat2_inh: valid=%b in=%h ex=%h required 0 %h %h", sum_valid, in_sum, ex_sum, P0_5, P1_0);
    end
    beat(P2_25, 1'b0, 1'b1);
    checks++;
    if (sum_valid !== 1'b1 || ex_sum !== P3_25 || in_sum !== P0_5 || spike_count !== 16'd3 ||
        overflow !== 1'b0 || spike_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL v1_sums: valid=%b ex=%h in=%h cnt=%0d ovf=%b ready=%b required 1 %h %h 3 0 0",
               sum_valid, ex_sum, in_sum, spike_count, overflow, spike_ready, P3_25, P0_5);
    end
    accept();
    checks++;
    if ({sum_valid, busy} !== 2'b00 || ex_sum !== P3_25) begin
      errors++;
      $display("FAIL v1_accept: valid/busy=%b ex=%h required 00 %h", {sum_valid, busy}, ex_sum, P3_25);
    end
    $display("basic: ex=%h in=%h cnt=%0d", ex_sum, in_sum, spike_count);
  endtask

  task automatic test_saturation();
    do_start();
    beat(BIG, 1'b0, 1'b0);
    beat(P2_0, 1'b0, 1'b1);
    checks++;
    if (ex_sum !== SATMAX || overflow !== 1'b1 || sum_valid !== 1'b1 || spike_count !== 16'd2) begin
      errors++;
      $display("FAIL pos_saturate: ex=%h ovf=%b valid=%b cnt=%0d required %h 1 1 2",
               ex_sum, overflow, sum_valid, spike_count, SATMAX);
    end
    accept();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky_idle: ovf=%b required 1", overflow);
    end
    do_start();
    checks++;
    if (overflow !== 1'b0 || ex_sum !== '0 || in_sum !== '0) begin
      errors++;
      $display("FAIL start_clears: ovf=%b ex=%h in=%h required 0 0 0", overflow, ex_sum, in_sum);
    end
    beat(SATMIN, 1'b0, 1'b0);
    beat(P0_5, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b0 || ex_sum !== SATMIN) begin
      errors++;
      $display("FAIL no_false_ovf: ovf=%b ex=%h required 0 %h", overflow, ex_sum, SATMIN);
    end
    beat(M1_0, 1'b0, 1'b1);
    checks++;
    if (ex_sum !== SATMIN || overflow !== 1'b1 || in_sum !== P0_5) begin
      errors++;
      $display("FAIL neg_saturate: ex=%h ovf=%b in=%h required %h 1 %h", ex_sum, overflow, in_sum, SATMIN, P0_5);
    end
    accept();
    $display("saturation: ex=%h ovf=%b", ex_sum, overflow);
  endtask

  task automatic test_hold();
    do_start();
    beat(M1_0, 1'b0, 1'b0);
    beat(M3_0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (sum_valid !== 1'b1 || ex_sum !== M1_0 || in_sum !== M3_0 || spike_count !== 16'd2) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b ex=%h in=%h cnt=%0d required 1 %h %h 2",
                 i, sum_valid, ex_sum, in_sum, spike_count, M1_0, M3_0);
      end
      tick();
    end
    accept();
    checks++;
    if ({sum_valid, busy} !== 2'b00 || in_sum !== M3_0) begin
      errors++;
      $display("FAIL hold_accept: valid/busy=%b in=%h required 00 %h", {sum_valid, busy}, in_sum, M3_0);
    end
    $display("hold: ex=%h in=%h", ex_sum, in_sum);
  endtask

  task automatic test_start_ignored();
    do_start();
    beat(P1_0, 1'b0, 1'b0);
    do_start();
    checks++;
    if (ex_sum !== P1_0 || spike_count !== 16'd1 || spike_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_accum: ex=%h cnt=%0d ready=%b required %h 1 1", ex_sum, spike_count, spike_ready, P1_0);
    end
    beat(P0_5, 1'b1, 1'b1);
    do_start();
    checks++;
    if (sum_valid !== 1'b1 || ex_sum !== P1_0 || spike_count !== 16'd2) begin
      errors++;
      $display("FAIL start_in_hold: valid=%b ex=%h cnt=%0d required 1 %h 2", sum_valid, ex_sum, spike_count, P1_0);
    end
    start = 1'b1; sum_accept = 1'b1;
    tick();
    start = 1'b0; sum_accept = 1'b0;
    checks++;
    if ({sum_valid, busy, spike_ready} !== 3'b000 || ex_sum !== P1_0 || in_sum !== P0_5) begin
      errors++;
      $display("FAIL start_accept_same: flags=%b ex=%h in=%h required 000 %h %h",
               {sum_valid, busy, spike_ready}, ex_sum, in_sum, P1_0, P0_5);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || spike_count !== 16'd2) begin
      errors++;
      $display("FAIL start_dropped: busy=%b cnt=%0d required 0 2", busy, spike_count);
    end
    $display("start_ignored: ex=%h in=%h", ex_sum, in_sum);
  endtask

  task automatic test_async_reset();
    do_start();
    beat(P1_0, 1'b0, 1'b0);
    beat(P0_5, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ex_sum, in_sum} !== {DW*2{1'b0}} || spike_count !== '0 ||
        {sum_valid, spike_ready, overflow, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: ex=%h in=%h cnt=%0d flags=%b required all zero",
               ex_sum, in_sum, spike_count, {sum_valid, spike_ready, overflow, busy});
    end
    tick();
    rst = 1'b0;
    spike_valid = 1'b1; spike_last = 1'b1; spike_weight = P1_0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sum_valid !== 1'b0 || busy !== 1'b0 || ex_sum !== '0) begin
        errors++;
        $display("FAIL after_reset[%0d]: valid=%b busy=%b ex=%h required 0 0 0", i, sum_valid, busy, ex_sum);
      end
    end
    spike_valid = 1'b0; spike_last = 1'b0; spike_weight = '0;
    $display("async_reset: ex=%h cnt=%0d", ex_sum, spike_count);
  endtask

  task automatic test_ignored_inputs();
    do_start();
    beat(P1_0, 1'b0, 1'b1);
    beat(P2_0, 1'b0, 1'b1);
    checks++;
    if (ex_sum !== P1_0 || spike_count !== 16'd1 || sum_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_in_hold: ex=%h cnt=%0d valid=%b required %h 1 1", ex_sum, spike_count, sum_valid, P1_0);
    end
    accept();
    sum_accept = 1'b1;
    beat(P2_0, 1'b1, 1'b1);
    sum_accept = 1'b0;
    checks++;
    if (ex_sum !== P1_0 || in_sum !== '0 || spike_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_in_idle: ex=%h in=%h cnt=%0d busy=%b required %h 0 1 0",
               ex_sum, in_sum, spike_count, busy, P1_0);
    end
    do_start();
    spike_last = 1'b1; spike_weight = P2_0;
    tick();
    spike_last = 1'b0; spike_weight = '0;
    checks++;
    if (spike_ready !== 1'b1 || sum_valid !== 1'b0 || spike_count !== '0 || ex_sum !== '0) begin
      errors++;
      $display("FAIL last_no_valid: ready=%b valid=%b cnt=%0d ex=%h required 1 0 0 0",
               spike_ready, sum_valid, spike_count, ex_sum);
    end
    beat(P0_5, 1'b1, 1'b1);
    checks++;
    if (sum_valid !== 1'b1 || in_sum !== P0_5 || spike_count !== 16'd1) begin
      errors++;
      $display("FAIL frame_after_ignore: valid=%b in=%h cnt=%0d required 1 %h 1", sum_valid, in_sum, spike_count, P0_5);
    end
    accept();
    $display("ignored_inputs: ex=%h in=%h cnt=%0d", ex_sum, in_sum, spike_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_hold();
    test_start_ignored();
    test_async_reset();
    test_ignored_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
